cdb_arbiter: RTL

- Shares the single common data bus (CDB) between N functional units (ALU, MMU, later FPU/branch) with round-robin arbitration.
- Replaces the combinational fixed-priority CDB mux in the core.
- The winning unit's result is captured into a registered broadcast stage, so the CDB is driven from a flop one cycle after grant.
- Supports a pipeline flush (branch miss) and a per-unit enable mask for configuration and debug.

---
 rtl/fcpu_pkg.sv | 17 +
 rtl/cdb_arbiter_if.sv | 36 +++
 rtl/cdb_arbiter_rr_pick.sv | 26 ++
 rtl/cdb_arbiter.sv | 60 ++++++
 4 files changed

// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared core types and constants, including the CDB result word and unit indices.
package fcpu_pkg;
  localparam int RSV_ID_W = 8;
  localparam int DATA_W = 32;
  localparam int CDB_W = RSV_ID_W + DATA_W;
  localparam int CDB_UNITS_MAX = 8;
  localparam int UNIT_ALU = 0;
  localparam int UNIT_MMU = 1;
  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0] data;
  } cdb_t;
  // index width that stays legal for a single-entry range
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: unit request/grant and CDB broadcast bundle; stats ports under CDB_ARB_STATS_EN.
interface cdb_arbiter_if #(
  parameter int N_UNITS = 2,
  parameter int CDB_W = fcpu_pkg::CDB_W
);
  localparam int IDX_W = fcpu_pkg::idx_w(N_UNITS);
  logic [N_UNITS-1:0] unit_valid;
  logic [N_UNITS*CDB_W-1:0] unit_cdb;
  logic [N_UNITS-1:0] unit_ready;
  logic [N_UNITS-1:0] unit_en_mask;
  logic flush;
  logic [CDB_W-1:0] cdb;
  logic cdb_valid;
  logic [IDX_W-1:0] cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic stat_clear;
  logic [N_UNITS*16-1:0] stat_conflicts;
  modport master (
    output unit_valid, unit_cdb, unit_en_mask, flush, stat_clear,
    input unit_ready, cdb, cdb_valid, cdb_src, stat_conflicts
  );
  modport slave (
    input unit_valid, unit_cdb, unit_en_mask, flush, stat_clear,
    output unit_ready, cdb, cdb_valid, cdb_src, stat_conflicts
  );
`else
  modport master (
    output unit_valid, unit_cdb, unit_en_mask, flush,
    input unit_ready, cdb, cdb_valid, cdb_src
  );
  modport slave (
    input unit_valid, unit_cdb, unit_en_mask, flush,
    output unit_ready, cdb, cdb_valid, cdb_src
  );
`endif
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational circular first-one finder starting at ptr, one-hot result.
module rr_pick
  import fcpu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt
);
  localparam int IW = idx_w(N);
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return IW'(s >= N ? s - N : s);
  endfunction
  // scan farthest-first so the nearest requester from ptr is the last writer
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[wrap(ptr, k)]) begin
        gnt = '0;
        gnt[wrap(ptr, k)] = 1'b1;
      end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with registered broadcast stage, flush and enable mask.
// Optional per-unit conflict counters when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_UNITS = 2,
  parameter int CDB_W = fcpu_pkg::CDB_W
) (
  input logic clk,
  input logic rst,
  cdb_arbiter_if.slave bus
);
  localparam int IDX_W = idx_w(N_UNITS);
  logic [N_UNITS-1:0] elig, gnt;
  logic [IDX_W-1:0] rr_ptr, gnt_idx, src_q;
  logic [CDB_W-1:0] sel, cdb_q;
  logic cdb_valid_q, xfer;
  assign elig = bus.unit_valid & bus.unit_en_mask & {N_UNITS{~bus.flush & ~rst}};
  rr_pick #(.N(N_UNITS)) u_pick (.req(elig), .ptr(rr_ptr), .gnt(gnt));
  assign xfer = |gnt;
  always_comb begin
    gnt_idx = '0;
    sel = '0;
    for (int i = 0; i < N_UNITS; i++)
      if (gnt[i]) begin
        gnt_idx = IDX_W'(i);
        sel = bus.unit_cdb[i*CDB_W +: CDB_W];
      end
  end
  // flush and rst both empty the grant, so the broadcast stage sees no transfer
  always_ff @(posedge clk)
    if (rst) begin
      cdb_q <= '0;
      cdb_valid_q <= 1'b0;
      src_q <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_valid_q <= xfer;
      if (xfer) begin
        cdb_q <= sel;
        src_q <= gnt_idx;
        rr_ptr <= gnt_idx == IDX_W'(N_UNITS - 1) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  assign bus.unit_ready = gnt;
  assign bus.cdb = cdb_q;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src = src_q;
`ifdef CDB_ARB_STATS_EN
  logic [15:0] conf_cnt [N_UNITS];
  always_ff @(posedge clk)
    for (int i = 0; i < N_UNITS; i++)
      if (rst || bus.stat_clear) conf_cnt[i] <= '0;
      else if (bus.unit_valid[i] && bus.unit_en_mask[i] && !gnt[i] && !bus.flush && conf_cnt[i] != 16'hFFFF)
        conf_cnt[i] <= conf_cnt[i] + 16'd1;
  for (genvar g = 0; g < N_UNITS; g++) begin : g_stat
    assign bus.stat_conflicts[g*16 +: 16] = conf_cnt[g];
  end
`endif
endmodule
